hw3proc_led_ctrl: RTL and testbench

- Parametrised Avalon-MM slave LED output controller. Successor to the fixed 18-bit LED PIO.
- Adds atomic set/clear/toggle registers, a per-bit hardware blink mask driven by a programmable prescaler, and a status readback.
- Sits on the processor's Avalon bus. `out_port` drives the board LEDs directly.

---
 rtl/hw3proc_led_ctrl_pkg.sv | 23 ++
 rtl/hw3proc_led_blink_timer.sv | 36 +++
 rtl/hw3proc_led_ctrl.sv | 121 ++++++++++++
 tb/tb_hw3proc_led_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hw3proc_led_ctrl_pkg.sv
// Shared constants for the LED controller: register addresses, STATUS layout, DUTY reset.
package hw3proc_led_ctrl_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
  localparam logic [2:0] ADDR_PERIOD     = 3'd2;
  localparam logic [2:0] ADDR_SET        = 3'd3;
  localparam logic [2:0] ADDR_CLEAR      = 3'd4;
  localparam logic [2:0] ADDR_TOGGLE     = 3'd5;
  localparam logic [2:0] ADDR_STATUS     = 3'd6;
  localparam logic [2:0] ADDR_DUTY       = 3'd7;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_CNT_LSB   = 1;

  localparam logic [7:0] DUTY_RESET = 8'hFF;

  // The PWM count sits directly above the prescaler count in STATUS.
  function automatic int status_pwm_lsb(input int div_width);
    return div_width + STATUS_CNT_LSB;
  endfunction

endpackage

// File: rtl/hw3proc_led_blink_timer.sv
// Blink prescaler: counts 0..period, toggling phase on each wrap; period 0 parks phase high.
module hw3proc_led_blink_timer #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic                 restart,
  output logic                 phase,
  output logic [DIV_WIDTH-1:0] cnt
);

  logic [DIV_WIDTH-1:0] cnt_r;
  logic                 phase_r;

  // Prescaler count and phase; restart wins so a shorter new period never overshoots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r   <= {DIV_WIDTH{1'b0}};
      phase_r <= 1'b1;
    end else if (restart || (period == {DIV_WIDTH{1'b0}})) begin
      cnt_r   <= {DIV_WIDTH{1'b0}};
      phase_r <= 1'b1;
    end else if (cnt_r >= period) begin
      cnt_r   <= {DIV_WIDTH{1'b0}};
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + DIV_WIDTH'(1);
      phase_r <= phase_r;
    end
  end

  assign cnt   = cnt_r;
  assign phase = phase_r;

endmodule

// File: rtl/hw3proc_led_ctrl.sv
// Avalon-MM LED controller with atomic set/clear/toggle and hardware blink.
// Optional PWM dimming on address 7 is enabled by defining HW3PROC_LED_CTRL_PWM_EN.
module hw3proc_led_ctrl #(
  parameter int               WIDTH       = 18,
  parameter int               DIV_WIDTH   = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  import hw3proc_led_ctrl_pkg::*;

  logic [WIDTH-1:0]     data_r;
  logic [WIDTH-1:0]     mask_r;
  logic [DIV_WIDTH-1:0] period_r;
  logic                 wr_en_s;
  logic                 restart_s;
  logic [WIDTH-1:0]     wd_s;
  logic                 phase_s;
  logic [DIV_WIDTH-1:0] cnt_s;
  logic [63:0]          status_s;
  logic                 unused_s;

  assign wr_en_s   = chipselect && !write_n;
  assign restart_s = wr_en_s && (address == ADDR_PERIOD);
  assign wd_s      = writedata[WIDTH-1:0];

  // Register file; SET/CLEAR/TOGGLE are read-modify-write views of DATA.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r   <= RESET_VALUE;
      mask_r   <= {WIDTH{1'b0}};
      period_r <= {DIV_WIDTH{1'b0}};
    end else if (wr_en_s) begin
      case (address)
        ADDR_DATA:       data_r   <= wd_s;
        ADDR_BLINK_MASK: mask_r   <= wd_s;
        ADDR_PERIOD:     period_r <= writedata[DIV_WIDTH-1:0];
        ADDR_SET:        data_r   <= data_r | wd_s;
        ADDR_CLEAR:      data_r   <= data_r & ~wd_s;
        ADDR_TOGGLE:     data_r   <= data_r ^ wd_s;
        default:         data_r   <= data_r;
      endcase
    end
  end

  hw3proc_led_blink_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_blink_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period_r),
    .restart (restart_s),
    .phase   (phase_s),
    .cnt     (cnt_s)
  );

`ifdef HW3PROC_LED_CTRL_PWM_EN
  logic [7:0] duty_r;
  logic [7:0] pwm_cnt_r;

  // Free-running PWM counter and DUTY register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_r    <= DUTY_RESET;
      pwm_cnt_r <= 8'd0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
      if (wr_en_s && (address == ADDR_DUTY)) begin
        duty_r <= writedata[7:0];
      end else begin
        duty_r <= duty_r;
      end
    end
  end

  assign status_s = (64'(phase_s) << STATUS_PHASE_BIT)
                  | (64'(cnt_s) << STATUS_CNT_LSB)
                  | (64'(pwm_cnt_r) << status_pwm_lsb(DIV_WIDTH));
`else
  assign status_s = (64'(phase_s) << STATUS_PHASE_BIT)
                  | (64'(cnt_s) << STATUS_CNT_LSB);
`endif

  // Zero wait-state read mux; chipselect deliberately does not gate it.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:       readdata = 32'(data_r);
      ADDR_BLINK_MASK: readdata = 32'(mask_r);
      ADDR_PERIOD:     readdata = 32'(period_r);
      ADDR_STATUS:     readdata = status_s[31:0];
`ifdef HW3PROC_LED_CTRL_PWM_EN
      ADDR_DUTY:       readdata = 32'(duty_r);
`endif
      default:         readdata = 32'd0;
    endcase
  end

  // LED drive: masked bits are blanked while phase is low, then optionally PWM-gated.
  always_comb begin
    out_port = data_r & ~(mask_r & {WIDTH{~phase_s}});
`ifdef HW3PROC_LED_CTRL_PWM_EN
    if (pwm_cnt_r < duty_r) begin
      out_port = out_port;
    end else begin
      out_port = {WIDTH{1'b0}};
    end
`endif
  end

  assign unused_s = ^{writedata, status_s[63:32]};

endmodule

// File: tb/tb_hw3proc_led_ctrl.sv
// Self-checking bench for hw3proc_led_ctrl (default WIDTH=18, DIV_WIDTH=24).
// Honours HW3PROC_LED_CTRL_PWM_EN to exercise the optional PWM path.
module tb_hw3proc_led_ctrl;

  localparam int W  = 18;
  localparam int DW = 24;
  localparam logic [W-1:0] ALL = {W{1'b1}};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;

  hw3proc_led_ctrl #(.WIDTH(W), .DIV_WIDTH(DW), .RESET_VALUE({W{1'b0}})) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Reference model: registers plus "edges since last restart" and "edges since reset".
  logic [W-1:0]  m_data, m_mask;
  logic [DW-1:0] m_period;
  longint        m_k, m_edges;
  logic [7:0]    m_duty;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data <= '0; m_mask <= '0; m_period <= '0; m_k <= 0; m_edges <= 0; m_duty <= 8'hFF;
    end else begin
      m_edges <= m_edges + 1;
      m_k <= m_k + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data <= writedata[W-1:0];
          3'd1: m_mask <= writedata[W-1:0];
          3'd2: begin m_period <= writedata[DW-1:0]; m_k <= 0; end
          3'd3: m_data <= m_data | writedata[W-1:0];
          3'd4: m_data <= m_data & ~writedata[W-1:0];
          3'd5: m_data <= m_data ^ writedata[W-1:0];
          3'd7: m_duty <= writedata[7:0];
          default: ;
        endcase
      end
    end
  end

  function automatic longint m_cnt();
    if (m_period == 0) return 0;
    return m_k % (longint'(m_period) + 1);
  endfunction

  function automatic logic m_phase();
    if (m_period == 0) return 1'b1;
    return ((m_k / (longint'(m_period) + 1)) % 2) == 0;
  endfunction

  function automatic logic [W-1:0] exp_out();
    logic [W-1:0] v;
    v = m_phase() ? m_data : (m_data & ~m_mask);
`ifdef HW3PROC_LED_CTRL_PWM_EN
    if ((m_edges % 256) >= longint'(m_duty)) v = '0;
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    longint st;
    case (a)
      3'd0: return 32'(m_data);
      3'd1: return 32'(m_mask);
      3'd2: return 32'(m_period);
      3'd6: begin
        st = longint'(m_phase()) + m_cnt() * 2;
`ifdef HW3PROC_LED_CTRL_PWM_EN
        st = st + (m_edges % 256) * (longint'(1) << (DW + 1));
`endif
        return st[31:0];
      end
`ifdef HW3PROC_LED_CTRL_PWM_EN
      3'd7: return 32'(m_duty);
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("out_port_model", 32'(out_port), 32'(exp_out()));
    check("readdata_model", readdata, exp_read(address));
  end

  // All driving happens 1ns after a rising edge; a write lands on the next edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a; #1;
    check(name, readdata, exp);
  endtask

  int hi_cnt;

  initial begin
    idle(2);
    reset_n = 1'b1;
    idle(1);
    check("reset_out", 32'(out_port), 32'h0);
    rd(3'd6, 32'h1, "reset_status");

    wr(3'd0, 32'h000F0); wr(3'd3, 32'h00003);
    check("set_out", 32'(out_port), 32'h000F3);
    rd(3'd0, 32'h000F3, "set_read");
    wr(3'd4, 32'h00030);
    check("clear_out", 32'(out_port), 32'h000C3);
    wr(3'd5, 32'h000FF);
    check("toggle_out", 32'(out_port), 32'h0003C);
    wr(3'd3, 32'hFFFFFFFF);
    rd(3'd0, 32'h3FFFF, "set_all_read");
    rd(3'd3, 32'h0, "read_set_zero");
    rd(3'd4, 32'h0, "read_clear_zero");
    rd(3'd5, 32'h0, "read_toggle_zero");
    wr(3'd7, 32'h000000AA);
`ifdef HW3PROC_LED_CTRL_PWM_EN
    rd(3'd7, 32'hAA, "duty_read");
    wr(3'd7, 32'hFF);
`else
    rd(3'd7, 32'h0, "addr7_read_zero");
`endif

    // Blink: bit0 low 4 edges after the PERIOD write edge, high again 4 later.
    wr(3'd1, 32'h00001);
    wr(3'd2, 32'd3);
    idle(3);
    check("blink_before", 32'(out_port), 32'h3FFFF);
    idle(1);
    check("blink_low", 32'(out_port), 32'h3FFFE);
    idle(3);
    check("blink_still_low", 32'(out_port), 32'h3FFFE);
    idle(1);
    check("blink_high", 32'(out_port), 32'h3FFFF);

    // Restart from mid-count with a smaller period.
    wr(3'd2, 32'd100);
    idle(50);
    rd(3'd6, 32'd101, "status_cnt50");
    wr(3'd2, 32'd2);
    rd(3'd6, 32'h1, "restart_status");
    idle(3);
    check("restart_low", 32'(out_port), 32'h3FFFE);
    rd(3'd6, 32'h0, "restart_status_low");

    // TOGGLE on the exact phase-toggle edges.
    idle(2);
    wr(3'd5, 32'h1);
    check("simul_toggle_a", 32'(out_port), 32'h3FFFE);
    rd(3'd0, 32'h3FFFE, "simul_data_a");
    idle(2);
    wr(3'd5, 32'h1);
    check("simul_toggle_b", 32'(out_port), 32'h3FFFE);
    rd(3'd0, 32'h3FFFF, "simul_data_b");

    // PERIOD=0 stops blinking: masked bit follows DATA.
    wr(3'd2, 32'd0);
    idle(10);
    check("stopped_out", 32'(out_port), 32'h3FFFF);
    wr(3'd4, 32'h1);
    check("stopped_follow", 32'(out_port), 32'h3FFFE);

    // Asynchronous reset mid-operation.
    wr(3'd3, 32'h1);
    wr(3'd2, 32'd5);
    idle(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_out", 32'(out_port), 32'h0);
    rd(3'd0, 32'h0, "async_reset_data");
    rd(3'd1, 32'h0, "async_reset_mask");
    rd(3'd2, 32'h0, "async_reset_period");
    rd(3'd6, 32'h1, "async_reset_status");
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);

`ifdef HW3PROC_LED_CTRL_PWM_EN
    wr(3'd0, 32'h3FFFF);
    wr(3'd7, 32'd64);
    hi_cnt = 0;
    repeat (256) begin
      if (out_port == ALL) hi_cnt++;
      idle(1);
    end
    check("pwm_duty64", 32'(hi_cnt), 32'd64);
    wr(3'd7, 32'd0);
    hi_cnt = 0;
    repeat (256) begin
      if (out_port != '0) hi_cnt++;
      idle(1);
    end
    check("pwm_duty0", 32'(hi_cnt), 32'd0);
`else
    wr(3'd0, 32'h3FFFF);
    hi_cnt = 0;
    repeat (64) begin
      if (out_port == ALL) hi_cnt++;
      idle(1);
    end
    check("no_pwm_always_on", 32'(hi_cnt), 32'd64);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
